// File: rtl/escritura_rafaga.sv
// Burst write sequencer for the RTC bus driver. It writes 1..MAX_BURST consecutive registers
// from a valid/ready stream, then issues the clock and/or timer transfer command(s).
// Optional build macro ESCRITURA_RAFAGA_TIMEOUT_EN enables the fin timeout watchdog.
module escritura_rafaga #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                MAX_BURST   = 4,
    parameter int                CNT_W       = 3,
    parameter logic [ADDR_W-1:0] TMR_LO      = 8'h41,
    parameter logic [ADDR_W-1:0] TMR_HI      = 8'h43,
    parameter logic [ADDR_W-1:0] CMD_CLK     = 8'hF0,
    parameter logic [ADDR_W-1:0] CMD_TMR     = 8'hF2,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] base_dir,
    input  logic [CNT_W-1:0]  num_regs,
    input  logic [DATA_W-1:0] dato,
    input  logic              dato_valid,
    output logic              dato_ready,
    input  logic              fin,
    output logic [ADDR_W-1:0] dir_out,
    output logic [DATA_W-1:0] data_out,
    output logic              escribe,
    output logic              activa,
    output logic              ocupado,
    output logic              final_rafaga,  // "final" is a reserved word in SystemVerilog
    output logic              error
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_NEXT     = 3'd3;
    localparam logic [2:0] S_XFER_CLK = 3'd4;
    localparam logic [2:0] S_XFER_TMR = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic              hit_clk, hit_tmr;
    logic [CNT_W-1:0]  num_clamp;
    logic              en_tmr;
    logic              waiting;
    logic              tmo_hit;

    assign num_clamp = (num_regs > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : num_regs;
    assign en_tmr    = (addr >= TMR_LO) && (addr <= TMR_HI);
    assign waiting   = (state == S_WRITE) || (state == S_XFER_CLK) || (state == S_XFER_TMR);

`ifdef ESCRITURA_RAFAGA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Waiting states are only left on fin (or abort/timeout into IDLE), so clearing on
    // fin and outside the waiting states restarts the count on every state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (!waiting || fin || abortar)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign tmo_hit = waiting && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            addr         <= '0;
            cnt          <= '0;
            hit_clk      <= 1'b0;
            hit_tmr      <= 1'b0;
            dato_ready   <= 1'b0;
            dir_out      <= '0;
            data_out     <= '0;
            escribe      <= 1'b0;
            activa       <= 1'b0;
            ocupado      <= 1'b0;
            final_rafaga <= 1'b0;
            error        <= 1'b0;
        end else begin
            final_rafaga <= 1'b0;
            error        <= 1'b0;
            if (abortar && state != S_IDLE) begin
                state      <= S_IDLE;
                dato_ready <= 1'b0;
                dir_out    <= '0;
                data_out   <= '0;
                escribe    <= 1'b0;
                activa     <= 1'b0;
                ocupado    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (iniciar) begin
                            addr    <= base_dir;
                            cnt     <= num_clamp;
                            hit_clk <= 1'b0;
                            hit_tmr <= 1'b0;
                            ocupado <= 1'b1;
                            if (num_clamp == '0) begin
                                state <= S_DONE;
                            end else begin
                                state      <= S_LOAD;
                                dato_ready <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (dato_valid && dato_ready) begin
                            dato_ready <= 1'b0;
                            dir_out    <= addr;
                            data_out   <= dato;
                            escribe    <= 1'b1;
                            activa     <= 1'b1;
                            state      <= S_WRITE;
                            if (en_tmr) hit_tmr <= 1'b1;
                            else        hit_clk <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (fin) begin
                            escribe <= 1'b0;
                            state   <= S_NEXT;
                        end else if (tmo_hit) begin
                            dir_out      <= '0;
                            data_out     <= '0;
                            escribe      <= 1'b0;
                            activa       <= 1'b0;
                            ocupado      <= 1'b0;
                            error        <= 1'b1;
                            final_rafaga <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                    S_NEXT: begin
                        addr <= addr + ADDR_W'(1);
                        cnt  <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            escribe <= 1'b1;
                            activa  <= 1'b1;
                            if (hit_clk) begin
                                dir_out  <= CMD_CLK;
                                data_out <= DATA_W'(CMD_CLK);
                                state    <= S_XFER_CLK;
                            end else begin
                                dir_out  <= CMD_TMR;
                                data_out <= DATA_W'(CMD_TMR);
                                state    <= S_XFER_TMR;
                            end
                        end else begin
                            dato_ready <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end
                    S_XFER_CLK, S_XFER_TMR: begin
                        // Clock command always precedes the timer command in a mixed burst.
                        if (fin && state == S_XFER_CLK && hit_tmr) begin
                            dir_out  <= CMD_TMR;
                            data_out <= DATA_W'(CMD_TMR);
                            state    <= S_XFER_TMR;
                        end else if (fin) begin
                            dir_out  <= '0;
                            data_out <= '0;
                            escribe  <= 1'b0;
                            activa   <= 1'b0;
                            state    <= S_DONE;
                        end else if (tmo_hit) begin
                            dir_out      <= '0;
                            data_out     <= '0;
                            escribe      <= 1'b0;
                            activa       <= 1'b0;
                            ocupado      <= 1'b0;
                            error        <= 1'b1;
                            final_rafaga <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                    S_DONE: begin
                        final_rafaga <= 1'b1;
                        ocupado      <= 1'b0;
                        state        <= S_IDLE;
                    end
                    default: begin
                        ocupado <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_escritura_rafaga.sv
// Directed bench for escritura_rafaga: bursts, clamp, wrap, stalls, abort, async reset, timeout.
module tb_escritura_rafaga;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, abortar = 1'b0, dato_valid = 1'b0, fin = 1'b0;
    logic [7:0] base_dir = 8'h00, dato = 8'h00;
    logic [2:0] num_regs = 3'd0;
    logic       dato_ready, escribe, activa, ocupado, final_rafaga, error;
    logic [7:0] dir_out, data_out;
    int         errors = 0, checks = 0;

    escritura_rafaga #(.TIMEOUT_CYC(10)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .abortar(abortar),
        .base_dir(base_dir), .num_regs(num_regs), .dato(dato), .dato_valid(dato_valid),
        .dato_ready(dato_ready), .fin(fin), .dir_out(dir_out), .data_out(data_out),
        .escribe(escribe), .activa(activa), .ocupado(ocupado),
        .final_rafaga(final_rafaga), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] b, input logic [2:0] n);
        base_dir = b;
        num_regs = n;
        iniciar  = 1'b1;
        tick();
        iniciar  = 1'b0;
    endtask

    // Bounded wait for the write strobe; reports whether it was seen.
    task automatic wait_esc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (escribe) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Bus driver acknowledges three cycles after the strobe edge.
    task automatic ack;
        tick();
        tick();
        fin = 1'b1;
        tick();
        fin = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({dato_ready, escribe, activa, ocupado, final_rafaga, error, dir_out, data_out} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {dato_ready, escribe, activa, ocupado, final_rafaga, error, dir_out, data_out});
        end
        #10 reset = 1'b0;
        tick();
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_idle ocupado=%b exp 0", ocupado); end
    endtask

    task automatic test_burst_clk;
        bit ok;
        dato = 8'hA5; dato_valid = 1'b1;
        start(8'h20, 3'd2);
        checks++;
        if (dato_ready !== 1'b1 || escribe !== 1'b0) begin
            errors++; $display("FAIL t1_load_latency ready=%b esc=%b exp 1/0", dato_ready, escribe);
        end
        tick();
        checks++;
        if (escribe !== 1'b1 || activa !== 1'b1 || dir_out !== 8'h20 || data_out !== 8'hA5) begin
            errors++; $display("FAIL t1_write0 esc=%b act=%b %h/%h exp 1 1 20/A5", escribe, activa, dir_out, data_out);
        end
        dato = 8'h5A;
        ack();
        checks++;
        if (escribe !== 1'b0 || activa !== 1'b1) begin
            errors++; $display("FAIL t1_next esc=%b act=%b exp 0/1", escribe, activa);
        end
        wait_esc(ok);
        checks++;
        if (!ok || dir_out !== 8'h21 || data_out !== 8'h5A) begin
            errors++; $display("FAIL t1_write1 ok=%b %h/%h exp 21/5A", ok, dir_out, data_out);
        end
        dato_valid = 1'b0;
        ack();
        wait_esc(ok);
        checks++;
        if (!ok || dir_out !== 8'hF0 || data_out !== 8'hF0) begin
            errors++; $display("FAIL t1_cmd_clk ok=%b %h/%h exp F0/F0", ok, dir_out, data_out);
        end
        ack();
        checks++;
        if (escribe !== 1'b0 || final_rafaga !== 1'b0 || dir_out !== 8'h00) begin
            errors++; $display("FAIL t1_done esc=%b fin=%b dir=%h exp 0 0 00 (no timer cmd)", escribe, final_rafaga, dir_out);
        end
        tick();
        checks++;
        if (final_rafaga !== 1'b1) begin errors++; $display("FAIL t1_final got %b exp 1", final_rafaga); end
        tick();
        checks++;
        if (final_rafaga !== 1'b0 || ocupado !== 1'b0) begin
            errors++; $display("FAIL t1_idle final=%b ocupado=%b exp 0/0", final_rafaga, ocupado);
        end
    endtask

    task automatic test_burst_both;
        bit ok;
        int nfinal;
        logic [7:0] exp_dir [3] = '{8'h42, 8'h43, 8'h44};
        dato = 8'h11; dato_valid = 1'b1;
        start(8'h42, 3'd3);
        for (int i = 0; i < 3; i++) begin
            wait_esc(ok);
            checks++;
            if (!ok || dir_out !== exp_dir[i]) begin
                errors++; $display("FAIL t2_write%0d ok=%b dir=%h exp %h", i, ok, dir_out, exp_dir[i]);
            end
            ack();
        end
        dato_valid = 1'b0;
        wait_esc(ok);
        checks++;
        if (!ok || dir_out !== 8'hF0) begin errors++; $display("FAIL t2_cmd_clk ok=%b dir=%h exp F0", ok, dir_out); end
        ack();
        checks++;
        if (escribe !== 1'b1 || dir_out !== 8'hF2 || data_out !== 8'hF2) begin
            errors++; $display("FAIL t2_cmd_tmr esc=%b %h/%h exp 1 F2/F2", escribe, dir_out, data_out);
        end
        ack();
        nfinal = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (final_rafaga) nfinal++;
        end
        checks++;
        if (nfinal != 1) begin errors++; $display("FAIL t2_final_count got %0d exp 1", nfinal); end
    endtask

    task automatic test_zero_and_clamp;
        bit ok;
        start(8'h10, 3'd0);
        checks++;
        if (dato_ready !== 1'b0 || escribe !== 1'b0 || final_rafaga !== 1'b0) begin
            errors++; $display("FAIL t3_zero_c1 ready=%b esc=%b final=%b exp 0 0 0", dato_ready, escribe, final_rafaga);
        end
        tick();
        checks++;
        if (final_rafaga !== 1'b1 || escribe !== 1'b0) begin
            errors++; $display("FAIL t3_zero_final final=%b esc=%b exp 1/0", final_rafaga, escribe);
        end
        tick();
        dato = 8'h77; dato_valid = 1'b1;
        start(8'h10, 3'd7);
        for (int i = 0; i < 4; i++) begin
            wait_esc(ok);
            checks++;
            if (!ok || dir_out !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL t3_clamp_w%0d ok=%b dir=%h exp %h", i, ok, dir_out, 8'h10 + 8'(i));
            end
            ack();
        end
        dato_valid = 1'b0;
        wait_esc(ok);
        checks++;
        if (!ok || dir_out !== 8'hF0) begin errors++; $display("FAIL t3_clamp_cmd ok=%b dir=%h exp F0 after 4 writes", ok, dir_out); end
        ack();
        tick();
        tick();
    endtask

    task automatic test_wrap_stall;
        bit ok;
        int bad;
        dato = 8'h11; dato_valid = 1'b1;
        start(8'hFF, 3'd2);
        wait_esc(ok);
        checks++;
        if (!ok || dir_out !== 8'hFF) begin errors++; $display("FAIL t4_dir_ff ok=%b dir=%h exp FF", ok, dir_out); end
        dato_valid = 1'b0;
        ack();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (escribe) bad++;
        end
        checks++;
        if (bad != 0 || dato_ready !== 1'b1) begin
            errors++; $display("FAIL t4_stall esc_cycles=%0d ready=%b exp 0/1", bad, dato_ready);
        end
        dato = 8'h22; dato_valid = 1'b1;
        wait_esc(ok);
        checks++;
        if (!ok || dir_out !== 8'h00 || data_out !== 8'h22) begin
            errors++; $display("FAIL t4_wrap ok=%b %h/%h exp 00/22", ok, dir_out, data_out);
        end
        dato_valid = 1'b0;
        ack();
        wait_esc(ok);
        ack();
        tick();
        tick();
    endtask

    task automatic test_abort_reset;
        bit ok;
        dato = 8'h33; dato_valid = 1'b1;
        start(8'h30, 3'd3);
        wait_esc(ok);
        ack();
        wait_esc(ok);
        dato_valid = 1'b0;
        abortar = 1'b1;
        fin = 1'b1;
        tick();
        abortar = 1'b0;
        fin = 1'b0;
        checks++;
        if (escribe !== 1'b0 || activa !== 1'b0 || ocupado !== 1'b0 || final_rafaga !== 1'b0) begin
            errors++; $display("FAIL t5_abort esc=%b act=%b ocu=%b final=%b exp 0 0 0 0", escribe, activa, ocupado, final_rafaga);
        end
        tick();
        checks++;
        if (final_rafaga !== 1'b0 || escribe !== 1'b0) begin
            errors++; $display("FAIL t5_abort_after final=%b esc=%b exp 0/0", final_rafaga, escribe);
        end
        dato_valid = 1'b1;
        start(8'h50, 3'd1);
        wait_esc(ok);
        dato_valid = 1'b0;
        ack();
        wait_esc(ok);
        checks++;
        if (!ok || dir_out !== 8'hF0) begin errors++; $display("FAIL t5_xfer ok=%b dir=%h exp F0", ok, dir_out); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({escribe, activa, ocupado, dato_ready, dir_out, data_out} !== 20'd0) begin
            errors++; $display("FAIL t5_async_reset got %h exp 0", {escribe, activa, ocupado, dato_ready, dir_out, data_out});
        end
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        bit ok;
        dato = 8'h44; dato_valid = 1'b1;
        start(8'h60, 3'd1);
        wait_esc(ok);
        dato_valid = 1'b0;
`ifdef ESCRITURA_RAFAGA_TIMEOUT_EN
        begin
            int n;
            n = 0;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (error) begin
                    n = i;
                    break;
                end
            end
            checks++;
            if (n != 10 || final_rafaga !== 1'b1 || escribe !== 1'b0) begin
                errors++; $display("FAIL t6_timeout cycles=%0d final=%b esc=%b exp 10 1 0", n, final_rafaga, escribe);
            end
            tick();
            checks++;
            if (error !== 1'b0 || ocupado !== 1'b0) begin
                errors++; $display("FAIL t6_timeout_pulse err=%b ocu=%b exp 0/0", error, ocupado);
            end
        end
`else
        begin
            int nerr;
            nerr = 0;
            repeat (1000) begin
                tick();
                if (error) nerr++;
            end
            checks++;
            if (nerr != 0 || escribe !== 1'b1 || ocupado !== 1'b1 || dir_out !== 8'h60) begin
                errors++; $display("FAIL t6_no_timeout err_cycles=%0d esc=%b ocu=%b dir=%h exp 0 1 1 60", nerr, escribe, ocupado, dir_out);
            end
            abortar = 1'b1;
            tick();
            abortar = 1'b0;
            checks++;
            if (ocupado !== 1'b0 || error !== 1'b0) begin
                errors++; $display("FAIL t6_cleanup ocu=%b err=%b exp 0/0", ocupado, error);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_burst_clk();
        test_burst_both();
        test_zero_and_clamp();
        test_wrap_stall();
        test_abort_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
